tdc_echo_proc: RTL
==================

TDC_ECHO_PROC -- requirements
Module: tdc_echo_proc

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 16'd20, minimum accepted pulse width in TDC LSB.
REQ-002 SHALL have parameter MAX_WIDTH, default 16'd4000, maximum accepted pulse width in TDC LSB.
REQ-003 SHALL have parameter TIMEOUT, default 20'd500000, clock cycles without i_angle_sync before a window is abandoned.
REQ-004 SHALL have ports, clock and reset first; one clock, reset asynchronous active-low:
- i_clk_100m  in  1  sole clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_angle_sync  in  1  one-cycle strobe; closes the current window and opens the next.
- i_motor_state  in  1  1 = motor speed stable.
- i_tdc_new_sig  in  1  one-cycle strobe; rise/fall/err valid.
- i_rise_data  in  24  rise timestamp.
- i_fall_data  in  24  fall timestamp.
- i_tdc_err_sig  in  1  TDC error flag for this sample.
- i_echo_ready  in  1  consumer accepts the result.
- o_echo_valid  out  1  result available.
- o_echo_rise  out  24  rise timestamp of the widest accepted echo.
- o_echo_width  out  16  width of that echo.
- o_echo_num  out  4  accepted echoes in window, saturating at 15.
- o_echo_miss  out  1  window closed with zero accepted echoes.
- o_echo_ovf  out  1  one-cycle pulse; an unconsumed result was overwritten.

Function
REQ-005 SHALL implement FSM states IDLE and COLLECT.
REQ-006 SHALL move IDLE->COLLECT on i_angle_sync=1 with i_motor_state=1; this sync produces no result.
REQ-007 SHALL move COLLECT->IDLE when i_motor_state=0 or TIMEOUT cycles pass without i_angle_sync; the window accumulators are discarded and no result is issued.
REQ-008 SHALL, on i_tdc_new_sig in COLLECT, compute raw = (i_fall_data - i_rise_data) mod 2^24; width = raw[15:0] if raw[23:16]==0, else 16'hFFFF.
REQ-009 SHALL accept a sample only if MIN_WIDTH <= width <= MAX_WIDTH, both bounds inclusive.
REQ-010 SHALL process each sample through a 2-stage pipeline: stage 1 registers inputs, stage 2 computes width and range check, then the accumulators update.
REQ-011 SHALL delay i_angle_sync internally by 2 cycles so that a sample strobed in the same cycle as i_angle_sync belongs to the closing window.
REQ-012 SHALL keep the widest accepted echo; on equal widths the earlier echo is retained.
REQ-013 SHALL, on a window close at sync cycle N, load the outputs and assert o_echo_valid at cycle N+3; accumulators clear the same cycle for the new window.
REQ-014 SHALL hold the outputs and o_echo_valid until i_echo_ready=1 while o_echo_valid=1; o_echo_valid deasserts the next cycle.
REQ-015 SHALL, if a new result arrives while o_echo_valid=1 and it is not being consumed that cycle, overwrite the outputs, keep o_echo_valid=1, and pulse o_echo_ovf for one cycle.
REQ-016 SHALL, with zero accepted echoes, issue a result with o_echo_miss=1, o_echo_rise=0, o_echo_width=0, o_echo_num=0.
REQ-017 SHALL ignore i_tdc_new_sig in IDLE.

Reset
REQ-018 SHALL, while i_rst_n=0, force FSM=IDLE, clear pipeline and accumulators, and drive every output to 0.
REQ-019 SHALL, on reset mid-window, drop any partial result; after release, wait for a fresh i_angle_sync per REQ-006.

Configuration
REQ-020 SHALL, with macro TDC_ERR_DROP_EN defined, reject any sample with i_tdc_err_sig=1 (it does not count in o_echo_num).
REQ-021 SHALL, without TDC_ERR_DROP_EN, ignore i_tdc_err_sig entirely.

Verification
REQ-022 Window with rise/fall 100/400, 1000/1100, 2000/2300 -> o_echo_rise=100, o_echo_width=300 (tie kept earliest), o_echo_num=3, valid at sync+3.
REQ-023 Rise 24'hFFFFF0, fall 24'h000010 -> width 32 accepted; fall-rise=5 and 5000 -> rejected, o_echo_miss=1 if alone.
REQ-024 new_sig (100/600) in the same cycle as i_angle_sync -> counted in closing window, width=500; next window starts empty.
REQ-025 i_echo_ready=0 across two window closes -> o_echo_ovf one-cycle pulse, second result shown; ready=1 -> valid drops next cycle.
REQ-026 i_motor_state=0 mid-window, or TIMEOUT reached -> IDLE, no result; err=1 sample (100/400) accepted without macro, rejected with TDC_ERR_DROP_EN.
REQ-027 i_rst_n=0 with o_echo_valid=1 -> all outputs 0 immediately; no result until 2nd sync after release.

Source files
------------

// File: rtl/tdc_echo_proc.sv
// rtl/tdc_echo_proc.sv - TDC echo window processor (widest echo per angle window); optional macro TDC_ERR_DROP_EN
module tdc_echo_proc #(
    parameter logic [15:0] MIN_WIDTH = 16'd20,
    parameter logic [15:0] MAX_WIDTH = 16'd4000,
    parameter logic [19:0] TIMEOUT   = 20'd500000
) (
    input  logic        i_clk_100m,
    input  logic        i_rst_n,
    input  logic        i_angle_sync,
    input  logic        i_motor_state,
    input  logic        i_tdc_new_sig,
    input  logic [23:0] i_rise_data,
    input  logic [23:0] i_fall_data,
    input  logic        i_tdc_err_sig,
    input  logic        i_echo_ready,
    output logic        o_echo_valid,
    output logic [23:0] o_echo_rise,
    output logic [15:0] o_echo_width,
    output logic [3:0]  o_echo_num,
    output logic        o_echo_miss,
    output logic        o_echo_ovf
);

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]  state;
    logic [19:0] to_cnt;
    logic        open_win;
    logic        close_win;
    logic        abort_win;

    logic        close_d1;
    logic        close_d2;

    logic        s1_vld;
    logic [23:0] s1_rise;
    logic [23:0] s1_fall;
`ifdef TDC_ERR_DROP_EN
    logic        s1_err;
`endif

    logic [23:0] raw_c;
    logic [15:0] width_c;
    logic        err_ok;
    logic        keep_c;

    logic        s2_vld;
    logic [23:0] s2_rise;
    logic [15:0] s2_width;

    logic [3:0]  acc_num;
    logic [23:0] acc_rise;
    logic [15:0] acc_width;

    logic        take_c;
    logic [3:0]  m_num;
    logic [23:0] m_rise;
    logic [15:0] m_width;

    // Window control: open on a stable-motor sync, close on each later sync, abort on motor loss or sync timeout
    always_comb begin
        open_win  = (state == ST_IDLE) && i_angle_sync && i_motor_state;
        close_win = (state == ST_COLLECT) && i_angle_sync && i_motor_state;
        abort_win = (state == ST_COLLECT) &&
                    (!i_motor_state || (!i_angle_sync && (to_cnt == TIMEOUT - 20'd1)));
    end

    // FSM and sync-timeout counter
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            to_cnt <= 20'd0;
        end else if (open_win) begin
            state  <= ST_COLLECT;
            to_cnt <= 20'd0;
        end else if (abort_win) begin
            state  <= ST_IDLE;
            to_cnt <= 20'd0;
        end else if (close_win) begin
            to_cnt <= 20'd0;
        end else if (state == ST_COLLECT) begin
            to_cnt <= to_cnt + 20'd1;
        end
    end

    // Close strobe delayed two cycles so it lines up with the sample pipeline
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            close_d1 <= 1'b0;
            close_d2 <= 1'b0;
        end else if (abort_win) begin
            close_d1 <= 1'b0;
            close_d2 <= 1'b0;
        end else begin
            close_d1 <= close_win;
            close_d2 <= close_d1;
        end
    end

    // Stage 1: register the raw TDC sample; strobes outside a window are ignored
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld  <= 1'b0;
            s1_rise <= 24'd0;
            s1_fall <= 24'd0;
`ifdef TDC_ERR_DROP_EN
            s1_err  <= 1'b0;
`endif
        end else begin
            s1_vld  <= (state == ST_COLLECT) && i_tdc_new_sig && !abort_win;
            s1_rise <= i_rise_data;
            s1_fall <= i_fall_data;
`ifdef TDC_ERR_DROP_EN
            s1_err  <= i_tdc_err_sig;
`endif
        end
    end

`ifdef TDC_ERR_DROP_EN
    assign err_ok = !s1_err;
`else
    // The error flag has no effect in this build
    assign err_ok = ~(i_tdc_err_sig & 1'b0);
`endif

    // Width with 24-bit wraparound, saturated to 16 bits, then range check
    always_comb begin
        raw_c   = s1_fall - s1_rise;
        width_c = (raw_c[23:16] == 8'd0) ? raw_c[15:0] : 16'hFFFF;
        keep_c  = s1_vld && err_ok && (width_c >= MIN_WIDTH) && (width_c <= MAX_WIDTH);
    end

    // Stage 2: register the width and accept decision
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vld   <= 1'b0;
            s2_rise  <= 24'd0;
            s2_width <= 16'd0;
        end else begin
            s2_vld   <= keep_c && !abort_win;
            s2_rise  <= s1_rise;
            s2_width <= width_c;
        end
    end

    // Merge the stage-2 sample into the running window; a tie keeps the earlier echo
    always_comb begin
        take_c  = s2_vld && ((acc_num == 4'd0) || (s2_width > acc_width));
        m_num   = (s2_vld && (acc_num != 4'd15)) ? acc_num + 4'd1 : acc_num;
        m_rise  = take_c ? s2_rise  : acc_rise;
        m_width = take_c ? s2_width : acc_width;
    end

    // Window accumulators, cleared when the window closes or aborts
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_num   <= 4'd0;
            acc_rise  <= 24'd0;
            acc_width <= 16'd0;
        end else if (close_d2 || abort_win) begin
            acc_num   <= 4'd0;
            acc_rise  <= 24'd0;
            acc_width <= 16'd0;
        end else begin
            acc_num   <= m_num;
            acc_rise  <= m_rise;
            acc_width <= m_width;
        end
    end

    // Result register with valid/ready hold and overwrite pulse
    always_ff @(posedge i_clk_100m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_echo_valid <= 1'b0;
            o_echo_rise  <= 24'd0;
            o_echo_width <= 16'd0;
            o_echo_num   <= 4'd0;
            o_echo_miss  <= 1'b0;
            o_echo_ovf   <= 1'b0;
        end else begin
            o_echo_ovf <= 1'b0;
            if (close_d2) begin
                o_echo_valid <= 1'b1;
                o_echo_rise  <= m_rise;
                o_echo_width <= m_width;
                o_echo_num   <= m_num;
                o_echo_miss  <= (m_num == 4'd0);
                o_echo_ovf   <= o_echo_valid && !i_echo_ready;
            end else if (o_echo_valid && i_echo_ready) begin
                o_echo_valid <= 1'b0;
            end
        end
    end

endmodule
